aes_round_seq: RTL

AES_ROUND_SEQ -- requirements
Module: aes_round_seq

---
 rtl/aes_round_seq.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/aes_round_seq.sv
// Iterative AES-128 encryptor: one shared round datapath walked through rounds 1..10 by an IDLE/RUN/DONE FSM.
// Optional macro AES_SEQ_ABORT_EN adds an abort input that cancels a running or finished operation.
module aes_round_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy,
    output logic [3:0]   round_idx
`ifdef AES_SEQ_ABORT_EN
    ,
    input  logic         abort
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   fsm;
    logic [127:0] state_q;
    logic [127:0] rk_q;
    logic [127:0] next_rk;
    logic [127:0] round_out;
    logic [3:0]   next_round;
    logic         abort_req;

`ifdef AES_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254) followed by the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        x252 = gmul(x240, x12);
        inv  = gmul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] v);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(v[8*i +: 8]);
        return r;
    endfunction

    // Byte k lives at bits [127-8k -: 8]; matrix[row][col] is byte 4*col+row.
    function automatic logic [127:0] shift_rows(input logic [127:0] v);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(4*c + row) -: 8] = v[127 - 8*(4*((c + row) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] v);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = v[127 - 32*c      -: 8];
            a1 = v[127 - 32*c - 8  -: 8];
            a2 = v[127 - 32*c - 16 -: 8];
            a3 = v[127 - 32*c - 24 -: 8];
            r[127 - 32*c      -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            r[127 - 32*c - 8  -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            r[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            r[127 - 32*c - 24 -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return r;
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Round 10 is the final round and skips mixColumns.
    always_comb begin
        logic [127:0] s;
        next_round = round_idx + 4'd1;
        next_rk    = expand_key(rk_q, rcon(next_round));
        s          = shift_rows(sub_bytes(state_q));
        if (next_round != 4'd10) s = mix_columns(s);
        round_out  = s ^ next_rk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            state_q   <= '0;
            rk_q      <= '0;
            round_idx <= 4'd0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state_q   <= plaintext ^ key;
                        rk_q      <= key;
                        round_idx <= 4'd0;
                        fsm       <= RUN;
                    end
                end
                RUN: begin
                    if (abort_req) begin
                        round_idx <= 4'd0;
                        fsm       <= IDLE;
                    end else begin
                        rk_q      <= next_rk;
                        state_q   <= round_out;
                        round_idx <= next_round;
                        if (round_idx == 4'd9) fsm <= DONE;
                    end
                end
                DONE: begin
                    if (abort_req) begin
                        round_idx <= 4'd0;
                        fsm       <= IDLE;
                    end else if (out_ready) begin
                        fsm <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign in_ready   = rst_n && (fsm == IDLE);
    assign out_valid  = (fsm == DONE);
    assign busy       = (fsm == RUN) || (fsm == DONE);
    assign ciphertext = out_valid ? state_q : 128'h0;

endmodule
